// File: rtl/spi_flash_writer.sv
// SPI mode-0 flash programmer: WRITE ENABLE, then PAGE PROGRAM of one word or 4 KB
// SECTOR ERASE, then status polling until WIP clears or the poll budget runs out.
module spi_flash_writer #(
   parameter int CS_GAP    = 4,
   parameter int MAX_POLLS = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wstrb,
   input  logic        estrb,
   input  logic [17:0] word_address,
   input  logic [31:0] wdata,
   output logic        wbusy,
   output logic        error,
   output logic        SCK,
   output logic        CS_N,
   output logic        MOSI,
   input  logic        MISO
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WREN  = 3'd1;
   localparam logic [2:0] GAP_A = 3'd2;
   localparam logic [2:0] CMD   = 3'd3;
   localparam logic [2:0] GAP_B = 3'd4;
   localparam logic [2:0] POLL  = 3'd5;
   localparam logic [2:0] GAP_C = 3'd6;

   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int PW = $clog2(MAX_POLLS + 1);

   logic [2:0]  state_q, state_d;
   logic [63:0] shift_q, shift_d;
   logic [6:0]  bits_left_q, bits_left_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [PW-1:0] poll_q, poll_d;
   logic        erase_q, erase_d;
   logic [17:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        cs_n_q, cs_n_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;
   logic        error_q, error_d;

   logic [23:0] byte_addr;
   logic [63:0] cmd_frame;
   logic [6:0]  cmd_bits;

   logic        load;
   logic [63:0] load_frame;
   logic [6:0]  load_bits;
   logic [2:0]  load_state;

   assign byte_addr = {4'b0001, addr_q, 2'b00};

   // Frames are left-aligned so every transaction shifts out from bit 63.
   assign cmd_frame = erase_q ? {8'h20, byte_addr[23:12], 12'h000, 32'h0000_0000}
                              : {8'h02, byte_addr, data_q[7:0], data_q[15:8],
                                 data_q[23:16], data_q[31:24]};
   assign cmd_bits  = erase_q ? 7'd32 : 7'd64;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bits_left_d = bits_left_q;
      gap_d       = gap_q;
      poll_d      = poll_q;
      erase_d     = erase_q;
      addr_d      = addr_q;
      data_d      = data_q;
      cs_n_d      = cs_n_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      error_d     = error_q;
      load        = 1'b0;
      load_frame  = '0;
      load_bits   = '0;
      load_state  = IDLE;

      case (state_q)
         IDLE: begin
            if (estrb || wstrb) begin
               erase_d = estrb;
               addr_d  = word_address;
               if (!estrb) begin
                  data_d = wdata;
               end
               error_d    = 1'b0;
               poll_d     = '0;
               load       = 1'b1;
               load_frame = {8'h06, 56'h0};
               load_bits  = 7'd8;
               load_state = WREN;
            end
         end

         WREN, CMD, POLL: begin
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               // Falling SCK edge: MISO is sampled here and MOSI moves to the next bit.
               sck_d = 1'b0;
               if (bits_left_q != 7'd1) begin
                  shift_d     = shift_q << 1;
                  mosi_d      = shift_q[62];
                  bits_left_d = bits_left_q - 7'd1;
               end else begin
                  cs_n_d = 1'b1;
                  mosi_d = 1'b0;
                  gap_d  = GW'(CS_GAP - 1);
                  if (state_q == WREN) begin
                     state_d = GAP_A;
                  end else if (state_q == CMD) begin
                     state_d = GAP_B;
                  end else if (!MISO) begin
                     state_d = IDLE;
                  end else if (poll_q == PW'(MAX_POLLS - 1)) begin
                     poll_d  = poll_q + PW'(1);
                     error_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     poll_d  = poll_q + PW'(1);
                     state_d = GAP_C;
                  end
               end
            end
         end

         GAP_A, GAP_B, GAP_C: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end else begin
               load = 1'b1;
               if (state_q == GAP_A) begin
                  load_frame = cmd_frame;
                  load_bits  = cmd_bits;
                  load_state = CMD;
               end else begin
                  load_frame = {8'h05, 56'h0};
                  load_bits  = 7'd16;
                  load_state = POLL;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase

      if (load) begin
         state_d     = load_state;
         cs_n_d      = 1'b0;
         sck_d       = 1'b0;
         shift_d     = load_frame;
         mosi_d      = load_frame[63];
         bits_left_d = load_bits;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bits_left_q <= '0;
         gap_q       <= '0;
         poll_q      <= '0;
         erase_q     <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         cs_n_q      <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bits_left_q <= bits_left_d;
         gap_q       <= gap_d;
         poll_q      <= poll_d;
         erase_q     <= erase_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cs_n_q      <= cs_n_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         error_q     <= error_d;
      end
   end

   assign wbusy = (state_q != IDLE);
   assign error = error_q;
   assign SCK   = sck_q;
   assign CS_N  = cs_n_q;
   assign MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: a behavioural SPI flash records every CS_N-low transaction
// and answers status reads; each operation is compared against a transaction-level model.
module tb_spi_flash_writer;

   localparam int CS_GAP    = 4;
   localparam int MAX_POLLS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wstrb;
   logic        estrb;
   logic [17:0] word_address;
   logic [31:0] wdata;
   logic        wbusy;
   logic        error;
   logic        SCK;
   logic        CS_N;
   logic        MOSI;
   logic        MISO = 1'b0;

   int checks = 0;
   int errors = 0;

   spi_flash_writer #(.CS_GAP(CS_GAP), .MAX_POLLS(MAX_POLLS)) dut (
      .clk(clk), .reset(reset), .wstrb(wstrb), .estrb(estrb),
      .word_address(word_address), .wdata(wdata), .wbusy(wbusy), .error(error),
      .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   // Flash model: written only here; the stimulus block just reads its records.
   logic [63:0] q_bits[$];
   int          q_n[$];
   int          q_cyc[$];
   int          q_gap[$];
   logic        prev_cs = 1'b1;
   logic        prev_sck = 1'b0;
   logic [63:0] cur_bits = '0;
   int          cur_n = 0;
   int          cur_cyc = 0;
   int          cur_gap = 0;
   int          high_cnt = 1000;
   int          poll_seen = 0;
   int          idle_viol = 0;
   logic [7:0]  status;

   // Written only by the stimulus block.
   int          busy_until = 0;
   bit          stuck = 1'b0;

   always @(negedge clk) begin
      if (CS_N === 1'b0) begin
         if (prev_cs) begin
            cur_bits = '0;
            cur_n    = 0;
            cur_cyc  = 0;
            cur_gap  = high_cnt;
         end
         cur_cyc++;
         if (SCK && !prev_sck) begin
            if (cur_n < 64) cur_bits[63-cur_n] = MOSI;
            cur_n++;
         end
      end else begin
         if (!prev_cs) begin
            q_bits.push_back(cur_bits);
            q_n.push_back(cur_n);
            q_cyc.push_back(cur_cyc);
            q_gap.push_back(cur_gap);
            if (cur_n == 16 && cur_bits[63:56] == 8'h05) poll_seen++;
            high_cnt = 0;
         end
         high_cnt++;
         if (SCK === 1'b1 || MOSI === 1'b1) idle_viol++;
      end
      status = {7'b1100101, (stuck || (poll_seen < busy_until))};
      if (CS_N === 1'b0 && SCK && cur_n > 8 && cur_n <= 16 && cur_bits[63:56] == 8'h05)
         MISO = status[16-cur_n];
      else
         MISO = 1'($urandom);
      prev_cs  = CS_N;
      prev_sck = SCK;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_cmd(input bit erase, input logic [17:0] wa,
                                           input logic [31:0] d);
      logic [23:0] ba;
      ba = 24'h100000 + {4'h0, wa, 2'b00};
      if (erase) return {8'h20, ba & 24'hFFF000, 32'h0};
      return {8'h02, ba, d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // One operation: strobe, wait out wbusy, then compare the whole transaction list.
   task automatic run_op(input string name, input bit do_w, input bit do_e,
                         input logic [17:0] wa, input logic [31:0] d,
                         input int nbusy, input bit stk, input int poke_at);
      int base, exp_polls, exp_cyc, busy_cyc, len, ntx, en;
      bit exp_err;
      logic [63:0] eb;
      base       = q_n.size();
      stuck      = stk;
      busy_until = poll_seen + nbusy;
      exp_err    = stk || (nbusy >= MAX_POLLS);
      exp_polls  = exp_err ? MAX_POLLS : nbusy + 1;
      len        = do_e ? 32 : 64;
      exp_cyc    = 16 + CS_GAP + 2*len + CS_GAP + exp_polls*32 + (exp_polls-1)*CS_GAP;

      @(negedge clk);
      check({name, " idle_before"}, 64'(wbusy), 64'(0));
      word_address = wa;
      wdata        = d;
      wstrb        = do_w;
      estrb        = do_e;
      @(negedge clk);
      wstrb = 1'b0;
      estrb = 1'b0;
      check({name, " busy_rise"}, 64'(wbusy), 64'(1));
      check({name, " err_clear"}, 64'(error), 64'(0));
      busy_cyc = 1;
      while (wbusy && busy_cyc < 20000) begin
         wstrb        = (busy_cyc == poke_at);
         estrb        = (busy_cyc == poke_at);
         word_address = 18'($urandom);
         wdata        = $urandom;
         @(negedge clk);
         if (wbusy) busy_cyc++;
      end
      wstrb = 1'b0;
      estrb = 1'b0;
      @(negedge clk);

      check({name, " wbusy_cycles"}, 64'(busy_cyc), 64'(exp_cyc));
      check({name, " error"}, 64'(error), 64'(exp_err));
      ntx = q_n.size() - base;
      check({name, " tx_count"}, 64'(ntx), 64'(2 + exp_polls));
      for (int i = 0; i < ntx && i < 2 + exp_polls; i++) begin
         if (i == 0) begin
            eb = {8'h06, 56'h0};
            en = 8;
         end else if (i == 1) begin
            eb = exp_cmd(do_e, wa, d);
            en = len;
         end else begin
            eb = {8'h05, 56'h0};
            en = 16;
         end
         check($sformatf("%s tx%0d bits", name, i), q_bits[base+i], eb);
         check($sformatf("%s tx%0d nbits", name, i), 64'(q_n[base+i]), 64'(en));
         check($sformatf("%s tx%0d cs_low", name, i), 64'(q_cyc[base+i]), 64'(2*en));
         if (i > 0)
            check($sformatf("%s tx%0d gap", name, i), 64'(q_gap[base+i]), 64'(CS_GAP));
      end
      check({name, " idle_lines"}, 64'(idle_viol), 64'(0));
      $display("op %s: w=%0d e=%0d addr=%05h data=%08h busy_polls=%0d cycles=%0d err=%0d",
               name, do_w, do_e, wa, d, nbusy, busy_cyc, error);
   endtask

   initial begin
      int base;
      reset        = 1'b1;
      wstrb        = 1'b0;
      estrb        = 1'b0;
      word_address = '0;
      wdata        = '0;
      repeat (3) @(negedge clk);
      check("reset CS_N", 64'(CS_N), 64'(1));
      check("reset SCK", 64'(SCK), 64'(0));
      check("reset MOSI", 64'(MOSI), 64'(0));
      check("reset wbusy", 64'(wbusy), 64'(0));
      check("reset error", 64'(error), 64'(0));
      reset = 1'b0;

      run_op("write", 1'b1, 1'b0, 18'h00010, 32'hDEADBEEF, 0, 1'b0, 0);
      run_op("erase", 1'b0, 1'b1, 18'h003FF, 32'h0, 0, 1'b0, 0);
      run_op("busy3", 1'b1, 1'b0, 18'($urandom), $urandom, 3, 1'b0, 0);
      run_op("timeout", 1'b1, 1'b0, 18'($urandom), $urandom, 0, 1'b1, 0);
      repeat (5) @(negedge clk);
      check("timeout sticky", 64'(error), 64'(1));
      run_op("after_to", 1'b1, 1'b0, 18'($urandom), $urandom, 0, 1'b0, 0);
      run_op("budget_edge", 1'b0, 1'b1, 18'($urandom), $urandom, MAX_POLLS, 1'b0, 0);
      run_op("collide", 1'b1, 1'b1, 18'($urandom), $urandom, 1, 1'b0, 0);
      run_op("poke", 1'b1, 1'b0, 18'($urandom), $urandom, 0, 1'b0, 50);

      // Reset while bit 20 of the program command is on the wire.
      @(negedge clk);
      word_address = 18'h2AAAA;
      wdata        = 32'h12345678;
      wstrb        = 1'b1;
      @(negedge clk);
      wstrb = 1'b0;
      repeat (60) @(negedge clk);
      check("rst cs_in_cmd", 64'(CS_N), 64'(0));
      base  = q_n.size();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst CS_N", 64'(CS_N), 64'(1));
      check("rst SCK", 64'(SCK), 64'(0));
      check("rst MOSI", 64'(MOSI), 64'(0));
      check("rst wbusy", 64'(wbusy), 64'(0));
      @(negedge clk);
      check("rst partial_count", 64'(q_n.size() - base), 64'(1));
      if (q_n.size() > base) check("rst partial_bits", 64'(q_n[base]), 64'(20));
      $display("op reset_mid_cmd: partial transactions=%0d", q_n.size() - base);
      run_op("post_rst", 1'b1, 1'b0, 18'h2AAAA, 32'h12345678, 0, 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         bit er;
         er = 1'($urandom);
         run_op($sformatf("rand%0d", k), !er, er, 18'($urandom), $urandom,
                int'($urandom_range(0, MAX_POLLS)), 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
